// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FWFT FIFO and its burst reader.
// Contents:
//   state_t      - reader FSM encoding (IDLE, BURST, DONE), built on
//                  plain localparam codes so older code can keep using them
//   level_width  - width of a FIFO occupancy count for a given depth
package fifo_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    BURST = ST_BURST,
    DONE  = ST_DONE
  } state_t;

  // The count has to represent 0..depth inclusive, hence the extra bit.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_out_reg.sv
// Single-entry registered valid/ready output stage.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   load                 - capture load_data/load_last this cycle
//   load_data, load_last - beat to capture
//   load_ok              - stage can take a beat this cycle
//   m_data, m_valid,
//   m_last, m_ready      - downstream stream
//
// Handshake: a beat transfers on any rising edge where m_valid && m_ready.
// While m_valid is high and m_ready is low, m_data/m_last are held stable.
// load_ok lets a new beat enter either into an empty stage or in the same
// cycle the current beat leaves, which gives one beat per cycle throughput.
module fifo_out_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ok,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready
);

  assign load_ok = !m_valid || m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else if (load) begin
      m_data  <= load_data;
      m_valid <= 1'b1;
      m_last  <= load_last;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a synchronous FWFT FIFO into a framed valid/ready stream.
// Full bursts of BURST_LEN beats go out as soon as enough data is buffered;
// a shorter burst of whatever is buffered goes out on flush or after
// TIMEOUT idle cycles with a partial fill. m_last marks each burst's end.
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   fifo_empty, fifo_level, fifo_data - FIFO read-side status and head entry
//   fifo_pop                          - combinational pop strobe to the FIFO
//   flush                             - send what is buffered (sampled in IDLE)
//   m_data, m_valid, m_last, m_ready  - output stream
//   busy                              - FSM is not in IDLE
//   state_dbg                         - raw FSM state for observation
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int FIFO_DEPTH = 16,
  parameter  int BURST_LEN  = 4,
  parameter  int TIMEOUT    = 15,
  localparam int LW         = level_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [LW-1:0]         fifo_level,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_pop,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  localparam int BLW = $clog2(BURST_LEN + 1);
  localparam int WCW = $clog2(TIMEOUT + 1);

  localparam logic [LW-1:0]  BURST_LVL = LW'(BURST_LEN);
  localparam logic [BLW-1:0] BURST_BL  = BLW'(BURST_LEN);
  localparam logic [BLW-1:0] ONE_BEAT  = BLW'(1);
  localparam logic [WCW-1:0] TIMEOUT_W = WCW'(TIMEOUT);

  state_t         state;
  logic [BLW-1:0] beats_left;
  logic [WCW-1:0] wait_cnt;
  logic           load_ok;

  // rst gates the pop so the FIFO is never drained while the reader is
  // being reset and about to discard what it holds.
  assign fifo_pop  = !rst && (state == BURST) && (beats_left != '0) &&
                     !fifo_empty && load_ok;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      beats_left <= '0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_level >= BURST_LVL) begin
            state      <= BURST;
            beats_left <= BURST_BL;
            wait_cnt   <= '0;
          end else if ((fifo_level != '0) && (flush || (wait_cnt == TIMEOUT_W))) begin
            // Only this block pops, so the level seen now is guaranteed to
            // still be there. The level is below BURST_LEN here, so it fits
            // in the beat counter.
            state      <= BURST;
            beats_left <= fifo_level[BLW-1:0];
            wait_cnt   <= '0;
          end else if (fifo_level == '0) begin
            wait_cnt <= '0;
          end else if (wait_cnt != TIMEOUT_W) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        BURST: begin
          if (fifo_pop) begin
            beats_left <= beats_left - 1'b1;
            if (beats_left == ONE_BEAT) state <= DONE;
          end
        end
        DONE: begin
          if (m_valid && m_ready && m_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  fifo_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (fifo_pop),
    .load_data (fifo_data),
    .load_last (beats_left == ONE_BEAT),
    .load_ok   (load_ok),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready)
  );

  // Running dry mid-burst means the level contract was broken upstream;
  // the pop condition already stalls, this just makes it visible.
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    ((state == BURST) && (beats_left != '0)) |-> !fifo_empty);

endmodule
